wb_router: RTL and testbench

WB_ROUTER -- requirements
Module: wb_router

---
 rtl/wb_router_if.sv | 26 ++
 rtl/wb_router.sv | 159 +++++++++++++++
 tb/tb_wb_router.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_router_if.sv
// Wishbone-style bus bundle shared by the router's upstream and downstream ports.
interface wb_bus;
  localparam int unsigned AdrW = 32;
  localparam int unsigned DatW = 32;
  localparam int unsigned SelW = 4;

  logic [AdrW-1:0] adr;
  logic [DatW-1:0] dat_w;
  logic [DatW-1:0] dat_r;
  logic [SelW-1:0] sel;
  logic            we;
  logic            stb;
  logic            cyc;
  logic            ack;
  logic            err;

  modport master (
    output adr, dat_w, sel, we, stb, cyc,
    input  dat_r, ack, err
  );

  modport slave (
    input  adr, dat_w, sel, we, stb, cyc,
    output dat_r, ack, err
  );
endinterface

// File: rtl/wb_router.sv
// Address-decoding Wishbone router: one upstream master, N downstream slaves,
// with decode-miss and slave-timeout error reporting.
module wb_router #(
  parameter int unsigned N                  = 2,
  parameter logic [31:0] AddrRanges [2*N]   = '{32'h0, 32'h2FFF, 32'h3000, 32'h3FFF},
  parameter int unsigned TIMEOUT            = 255
) (
  input  logic       clk_in,
  input  logic       reset_in,
  wb_bus.slave       bus_in,
  wb_bus.master      bus_out [N],
  output logic [7:0] decode_err_cnt,
  output logic [7:0] timeout_cnt
);

  localparam int unsigned SelW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned TmoW = 16;
  localparam int unsigned CntW = 8;
  localparam int unsigned DatW = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    ERR    = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [SelW-1:0]   sel_idx, sel_idx_d;
  logic [TmoW-1:0]   tmo_cnt, tmo_cnt_d;
  logic              dec_miss_c;
  logic              tmo_hit_c;

  logic [N-1:0]      hit;
  logic [N-1:0]      port_en;
  logic [N-1:0]      s_ack;
  logic [N-1:0]      s_err;
  logic [DatW-1:0]   s_dat [N];
  logic [SelW-1:0]   first_idx;
  logic              any_hit;

  logic              ack_c;
  logic              err_c;
  logic [DatW-1:0]   dat_c;

  // Per-port range compare, broadcast of request fields, and gating of strobes.
  for (genvar i = 0; i < N; i++) begin : g_port
    assign hit[i]     = (bus_in.adr >= AddrRanges[2*i]) && (bus_in.adr <= AddrRanges[2*i+1]);
    assign port_en[i] = (state_q == ACTIVE) && (sel_idx == SelW'(i));
    assign s_ack[i]   = bus_out[i].ack;
    assign s_err[i]   = bus_out[i].err;
    assign s_dat[i]   = bus_out[i].dat_r;

    assign bus_out[i].adr   = bus_in.adr;
    assign bus_out[i].dat_w = bus_in.dat_w;
    assign bus_out[i].sel   = bus_in.sel;
    assign bus_out[i].we    = bus_in.we;
    assign bus_out[i].cyc   = port_en[i] & bus_in.cyc;
    assign bus_out[i].stb   = port_en[i] & bus_in.stb;
  end

  // Lowest-index match wins when ranges overlap.
  always_comb begin
    first_idx = '0;
    any_hit   = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (hit[i]) begin
        first_idx = SelW'(i);
        any_hit   = 1'b1;
      end
    end
  end

  // Next-state, timeout counter and upstream response logic.
  always_comb begin
    state_d    = state_q;
    sel_idx_d  = sel_idx;
    tmo_cnt_d  = tmo_cnt;
    dec_miss_c = 1'b0;
    tmo_hit_c  = 1'b0;
    ack_c      = 1'b0;
    err_c      = 1'b0;
    dat_c      = '0;

    case (state_q)
      IDLE: begin
        if (bus_in.cyc && bus_in.stb) begin
          if (any_hit) begin
            state_d   = ACTIVE;
            sel_idx_d = first_idx;
            tmo_cnt_d = '0;
          end else begin
            state_d    = ERR;
            dec_miss_c = 1'b1;
          end
        end
      end

      ACTIVE: begin
        dat_c = s_dat[sel_idx];
        if (!bus_in.cyc) begin
          // Master abort: silently drop back to IDLE.
          state_d = IDLE;
        end else if (s_err[sel_idx]) begin
          err_c   = 1'b1;
          state_d = IDLE;
        end else if (s_ack[sel_idx]) begin
          ack_c   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt + TmoW'(1);
          if (tmo_cnt == TmoW'(TIMEOUT - 1)) begin
            state_d   = ERR;
            tmo_hit_c = 1'b1;
          end
        end
      end

      ERR: begin
        err_c   = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus_in.ack   = ack_c;
  assign bus_in.err   = err_c;
  assign bus_in.dat_r = dat_c;

  // FSM, selected index and timeout counter registers.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q <= IDLE;
      sel_idx <= '0;
      tmo_cnt <= '0;
    end else begin
      state_q <= state_d;
      sel_idx <= sel_idx_d;
      tmo_cnt <= tmo_cnt_d;
    end
  end

  // Saturating error event counters.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      decode_err_cnt <= '0;
      timeout_cnt    <= '0;
    end else begin
      if (dec_miss_c && (decode_err_cnt != {CntW{1'b1}})) begin
        decode_err_cnt <= decode_err_cnt + CntW'(1);
      end
      if (tmo_hit_c && (timeout_cnt != {CntW{1'b1}})) begin
        timeout_cnt <= timeout_cnt + CntW'(1);
      end
    end
  end

endmodule

// File: tb/tb_wb_router.sv
// Scoreboard bench for wb_router: two behavioural slaves, one scripted master.
module tb_wb_router;

  logic       clk_in;
  logic       reset_in;
  logic [7:0] decode_err_cnt;
  logic [7:0] timeout_cnt;

  wb_bus bus_m ();
  wb_bus bus_s [2] ();

  wb_router #(
    .N       (2),
    .TIMEOUT (8)
  ) dut (
    .clk_in         (clk_in),
    .reset_in       (reset_in),
    .bus_in         (bus_m),
    .bus_out        (bus_s),
    .decode_err_cnt (decode_err_cnt),
    .timeout_cnt    (timeout_cnt)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Slave behaviour: mode 0 ack, 1 err, 2 ack+err, 3 never respond.
  int          s_lat  [2];
  int          s_mode [2];
  logic [31:0] s_rdat [2];

  for (genvar i = 0; i < 2; i++) begin : g_slv
    int          cnt      = 0;
    int          stb_cnt  = 0;
    logic [31:0] last_wdat = '0;
    logic [3:0]  last_sel  = '0;

    always @(posedge clk_in) begin
      if (bus_s[i].cyc && bus_s[i].stb) begin
        cnt     <= cnt + 1;
        stb_cnt <= stb_cnt + 1;
        if (bus_s[i].we) begin
          last_wdat <= bus_s[i].dat_w;
          last_sel  <= bus_s[i].sel;
        end
      end else begin
        cnt <= 0;
      end
    end

    assign bus_s[i].ack   = bus_s[i].cyc && bus_s[i].stb && (cnt == s_lat[i]) &&
                            (s_mode[i] == 0 || s_mode[i] == 2);
    assign bus_s[i].err   = bus_s[i].cyc && bus_s[i].stb && (cnt == s_lat[i]) &&
                            (s_mode[i] == 1 || s_mode[i] == 2);
    assign bus_s[i].dat_r = s_rdat[i];
  end

  // Expected response: kind 0 none, 1 ack, 2 err; cyc = cycles after request;
  // stbs = {slave1.stb, slave0.stb} expected in the response cycle.
  typedef struct {
    int          kind;
    int          cyc;
    logic [31:0] data;
    logic [1:0]  stbs;
  } exp_t;

  exp_t sb [$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input int kind, input int cyc, input logic [31:0] data,
                          input logic [1:0] stbs);
    exp_t e;
    e.kind = kind;
    e.cyc  = cyc;
    e.data = data;
    e.stbs = stbs;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] stbs_now();
    return {30'b0, bus_s[1].stb, bus_s[0].stb};
  endfunction

  // Drive one transaction starting right after a clock edge, wait (bounded)
  // for a response, release the bus and score against the queue head.
  task automatic xfer(input string tag, input logic [31:0] adr, input logic [31:0] wdat,
                      input logic we, input int budget, input int abort_at);
    exp_t        e;
    int          got_kind = 0;
    int          got_cyc  = -1;
    logic [31:0] got_dat  = '0;
    logic [31:0] got_stbs = '0;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    bus_m.adr   = adr;
    bus_m.dat_w = wdat;
    bus_m.sel   = 4'hF;
    bus_m.we    = we;
    bus_m.cyc   = 1'b1;
    bus_m.stb   = 1'b1;
    for (int k = 0; k <= budget; k++) begin
      if (k == abort_at) begin
        bus_m.cyc = 1'b0;
        bus_m.stb = 1'b0;
      end
      @(negedge clk_in);
      if (abort_at >= 0 && k == abort_at + 1) check({tag, "_abort_stb"}, stbs_now(), 32'd0);
      if (bus_m.err) begin
        got_kind = 2; got_cyc = k; got_stbs = stbs_now();
      end else if (bus_m.ack) begin
        got_kind = 1; got_cyc = k; got_dat = bus_m.dat_r; got_stbs = stbs_now();
      end
      @(posedge clk_in);
      #1;
      if (got_kind != 0) break;
    end
    bus_m.cyc = 1'b0;
    bus_m.stb = 1'b0;
    bus_m.we  = 1'b0;
    @(negedge clk_in);
    check({tag, "_resp_once"}, {31'b0, bus_m.ack | bus_m.err}, 32'd0);
    check({tag, "_stb_after"}, stbs_now(), 32'd0);
    check({tag, "_kind"}, 32'(got_kind), 32'(e.kind));
    if (e.kind != 0) begin
      check({tag, "_latency"}, 32'(got_cyc), 32'(e.cyc));
      check({tag, "_resp_stb"}, got_stbs, {30'b0, e.stbs});
    end
    if (e.kind == 1) check({tag, "_data"}, got_dat, e.data);
    @(posedge clk_in);
    #1;
  endtask

  int s0_base, s1_base;

  initial begin
    reset_in    = 1'b0;
    bus_m.adr   = '0;
    bus_m.dat_w = '0;
    bus_m.sel   = '0;
    bus_m.we    = 1'b0;
    bus_m.cyc   = 1'b0;
    bus_m.stb   = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_lat[i]  = 0;
      s_mode[i] = 0;
      s_rdat[i] = '0;
    end
    repeat (3) @(posedge clk_in);
    #2;
    check("rst_ack", {31'b0, bus_m.ack}, 32'd0);
    check("rst_err", {31'b0, bus_m.err}, 32'd0);
    check("rst_dat", bus_m.dat_r, 32'd0);
    check("rst_stbs", stbs_now(), 32'd0);
    check("rst_dec_cnt", 32'(decode_err_cnt), 32'd0);
    check("rst_tmo_cnt", 32'(timeout_cnt), 32'd0);
    @(posedge clk_in);
    #1;
    reset_in = 1'b1;
    @(posedge clk_in);
    #1;

    // Read from slave0 with two-cycle slave latency.
    s_mode[0] = 0; s_lat[0] = 2; s_rdat[0] = 32'hDEADBEEF;
    s1_base = g_slv[1].stb_cnt;
    push_exp(1, 3, 32'hDEADBEEF, 2'b01);
    xfer("rd0", 32'h0000_0100, 32'h0, 1'b0, 20, -1);
    check("rd0_s1_untouched", 32'(g_slv[1].stb_cnt - s1_base), 32'd0);

    // Write to slave1.
    s_mode[1] = 0; s_lat[1] = 0; s_rdat[1] = 32'h0000_0011;
    s0_base = g_slv[0].stb_cnt;
    push_exp(1, 1, 32'h0000_0011, 2'b10);
    xfer("wr1", 32'h3004, 32'h12345678, 1'b1, 20, -1);
    check("wr1_wdat", g_slv[1].last_wdat, 32'h12345678);
    check("wr1_sel", {28'b0, g_slv[1].last_sel}, 32'hF);
    check("wr1_s0_untouched", 32'(g_slv[0].stb_cnt - s0_base), 32'd0);

    // Decode miss.
    s0_base = g_slv[0].stb_cnt;
    s1_base = g_slv[1].stb_cnt;
    push_exp(2, 1, 32'h0, 2'b00);
    xfer("miss", 32'h4000, 32'h0, 1'b0, 20, -1);
    check("miss_no_stb", 32'(g_slv[0].stb_cnt - s0_base + g_slv[1].stb_cnt - s1_base), 32'd0);
    check("miss_dec_cnt", 32'(decode_err_cnt), 32'd1);

    // Range boundaries.
    s_mode[0] = 0; s_lat[0] = 0; s_rdat[0] = 32'hA0A0_0000;
    s_mode[1] = 0; s_lat[1] = 1; s_rdat[1] = 32'hB1B1_0001;
    push_exp(1, 1, 32'hA0A0_0000, 2'b01);
    xfer("b_2fff", 32'h2FFF, 32'h0, 1'b0, 20, -1);
    push_exp(1, 2, 32'hB1B1_0001, 2'b10);
    xfer("b_3000", 32'h3000, 32'h0, 1'b0, 20, -1);
    push_exp(1, 2, 32'hB1B1_0001, 2'b10);
    xfer("b_3fff", 32'h3FFF, 32'h0, 1'b0, 20, -1);
    push_exp(2, 1, 32'h0, 2'b00);
    xfer("b_ffff", 32'hFFFF_FFFF, 32'h0, 1'b0, 20, -1);
    check("b_dec_cnt", 32'(decode_err_cnt), 32'd2);

    // Slave err alone, and ack+err together (err wins).
    s_mode[1] = 1; s_lat[1] = 0;
    push_exp(2, 1, 32'h0, 2'b10);
    xfer("serr", 32'h3010, 32'h0, 1'b0, 20, -1);
    s_mode[1] = 2; s_lat[1] = 1;
    push_exp(2, 2, 32'h0, 2'b10);
    xfer("ackerr", 32'h3020, 32'h0, 1'b0, 20, -1);

    // Master abort mid-transaction: no response, no timeout.
    s_mode[1] = 3;
    push_exp(0, -1, 32'h0, 2'b00);
    xfer("abort", 32'h3030, 32'h0, 1'b0, 14, 3);
    check("abort_tmo_cnt", 32'(timeout_cnt), 32'd0);

    // Slave timeout, then saturation of the timeout counter.
    s_mode[0] = 3;
    push_exp(2, 9, 32'h0, 2'b00);
    xfer("tmo", 32'h0000_0200, 32'h0, 1'b0, 20, -1);
    check("tmo_cnt_1", 32'(timeout_cnt), 32'd1);
    for (int n = 1; n < 300; n++) begin
      push_exp(2, 9, 32'h0, 2'b00);
      xfer("tmo_n", 32'h0000_0300, 32'h0, 1'b0, 20, -1);
      if (n == 254) check("tmo_cnt_255", 32'(timeout_cnt), 32'hFF);
    end
    check("tmo_cnt_sat", 32'(timeout_cnt), 32'hFF);
    check("dec_cnt_kept", 32'(decode_err_cnt), 32'd2);

    // Asynchronous reset while slave0 strobe is high.
    bus_m.adr = 32'h0000_0040;
    bus_m.we  = 1'b0;
    bus_m.cyc = 1'b1;
    bus_m.stb = 1'b1;
    repeat (2) @(posedge clk_in);
    #3;
    check("rst_mid_pre_stb", stbs_now(), 32'd1);
    reset_in = 1'b0;
    #1;
    check("rst_mid_stb", stbs_now(), 32'd0);
    check("rst_mid_err", {31'b0, bus_m.err | bus_m.ack}, 32'd0);
    check("rst_mid_tmo_cnt", 32'(timeout_cnt), 32'd0);
    check("rst_mid_dec_cnt", 32'(decode_err_cnt), 32'd0);
    bus_m.cyc = 1'b0;
    bus_m.stb = 1'b0;
    @(posedge clk_in);
    #1;
    reset_in = 1'b1;
    @(posedge clk_in);
    #1;
    s_mode[1] = 0; s_lat[1] = 0; s_rdat[1] = 32'hC0FF_EE01;
    push_exp(1, 1, 32'hC0FF_EE01, 2'b10);
    xfer("post_rst", 32'h3000, 32'h0, 1'b0, 20, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
